// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and sizes for the shift-and-add multiplier.
//   seq_state_t : control FSM state encoding (IDLE, LOAD, RUN, DONE)
//   MULT_W      : operand width (multiplicand / multiplier)
//   PROD_W      : product and multiplicand-register width (2*MULT_W)
//   CNT_W       : width of the RUN step counter (counts MULT_W steps)
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W = 8;
    localparam int PROD_W = 2 * MULT_W;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/shift_add_sequencer.sv
// -----------------------------------------------------------------------------
// shift_add_sequencer
// Control-and-accumulate stage of an 8x8 shift-and-add multiplier. It drives an
// external 16-bit loadable left-shift register that holds the multiplicand,
// walks the multiplier LSB-first, and adds the shifted multiplicand into an
// accumulator whenever the current multiplier bit is set.
//
// Ports:
//   clk      in   system clock; state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   multiply request, sampled only in IDLE
//   a        in   multiplicand (loaded into the external register)
//   b        in   multiplier (captured internally)
//   mcand_q  in   Q output of the external multiplicand register
//   l_o      out  parallel-load value {8'h00, captured a}
//   lds_o    out  register load select
//   ebl_o    out  register enable (gates the register clock)
//   sis_o    out  serial-in bit for the register, always 0
//   product  out  result, held until overwritten by the next multiply
//   busy     out  high whenever the FSM is not IDLE
//   done     out  one-cycle pulse when product becomes valid
// -----------------------------------------------------------------------------
module shift_add_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   mcand_q,
    output logic [2*WIDTH-1:0]   l_o,
    output logic                 lds_o,
    output logic                 ebl_o,
    output logic                 sis_o,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [MULT_W-1:0]  r_a;
    logic [MULT_W-1:0]  r_mplier;
    logic [PROD_W-1:0]  r_acc;
    logic [PROD_W-1:0]  r_product;
    logic [CNT_W-1:0]   r_cnt;
    logic [PROD_W-1:0]  w_addend;
    logic [PROD_W-1:0]  w_sum;

    // The external register already presents a<<k at step k, so the add is
    // just a gated pass of its output.
    assign w_addend = r_mplier[0] ? mcand_q : '0;
    assign w_sum    = r_acc + w_addend;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (start) w_next_state = LOAD;
            LOAD: w_next_state = RUN;
            RUN:  if (r_cnt == CNT_LAST) w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Rising-edge state and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every flop samples
            // pre-edge values regardless of process ordering.
            r_state   <= IDLE;
            r_a       <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_sum;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Take the final sum directly so product is valid in DONE.
                    if (r_cnt == CNT_LAST) r_product <= w_sum;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Falling-edge sideband to the multiplicand register. Launching half a
    // cycle late keeps ebl_o stable while clk is high, so clk & ebl_o cannot
    // glitch.
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lds_o <= 1'b0;
            ebl_o <= 1'b0;
            l_o   <= '0;
        end else begin
            lds_o <= (r_state == LOAD);
            ebl_o <= (r_state == LOAD) || (r_state == RUN);
            l_o   <= {{(PROD_W - MULT_W){1'b0}}, r_a};
        end
    end

    assign sis_o   = 1'b0;
    assign product = r_product;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);

endmodule

// File: tb/tb_shift_add_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_shift_add_sequencer
// Sequencer wired to a behavioural 16-bit loadable left-shift register.
// Stimulus pushes the hand-computed product into a queue; a monitor pops and
// compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_shift_add_sequencer;

    localparam real HALF = 5.0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] mcand_q;
    logic [15:0] l_o;
    logic        lds_o;
    logic        ebl_o;
    logic        sis_o;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [15:0] sb_q[$];

    always #HALF clk = ~clk;

    shift_add_sequencer #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .mcand_q (mcand_q),
        .l_o     (l_o),
        .lds_o   (lds_o),
        .ebl_o   (ebl_o),
        .sis_o   (sis_o),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    // External multiplicand register: clocked by the gated clock.
    logic        w_gclk;
    logic [15:0] r_q = '0;
    assign w_gclk  = clk & ebl_o;
    assign mcand_q = r_q;
    always @(posedge w_gclk) r_q <= lds_o ? l_o : {r_q[14:0], sis_o};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("product", 32'(product), 32'(sb_q.pop_front()));
            end
        end
    end

    // Sideband must only move on falling edges (or under reset).
    always @(ebl_o or lds_o) begin
        if (rst_n && clk) begin
            errors++;
            $display("FAIL sideband_edge: ebl_o=%0b lds_o=%0b changed while clk high at %0t",
                     ebl_o, lds_o, $time);
        end
    end

    // Gated clock pulses must be full half-periods.
    realtime t_rise = 0.0;
    always @(posedge w_gclk) t_rise = $realtime;
    always @(negedge w_gclk) begin
        if (rst_n && ($realtime - t_rise) < HALF) begin
            errors++;
            $display("FAIL gclk_width: pulse %0t ns narrower than %0t ns", $realtime - t_rise, HALF);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_product"}, 32'(product), 32'd0);
        check({tag, "_lds"},     32'(lds_o),   32'd0);
        check({tag, "_ebl"},     32'(ebl_o),   32'd0);
        check({tag, "_l"},       32'(l_o),     32'd0);
        check({tag, "_sis"},     32'(sis_o),   32'd0);
    endtask

    // One multiply. With hold set, start stays high afterwards.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                          input bit hold, input logic [7:0] mid_a, input logic [7:0] mid_b);
        int lat;
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        if (!hold) start = 1'b0;
        a = mid_a; b = mid_b;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        check("done_latency", 32'(lat), 32'd9);
        @(posedge clk); #1;
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); start = 1'($urandom);
            #2 check_reset_outputs("rst_hold");
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_after_release", 32'(busy), 32'd0);

        run_op(8'd13,  8'd11,  16'd143,   1'b0, 8'hAA, 8'h55);
        run_op(8'd255, 8'd255, 16'hFE01,  1'b0, 8'h00, 8'h00);
        run_op(8'd0,   8'd200, 16'd0,     1'b0, 8'hFF, 8'hFF);
        run_op(8'd77,  8'd0,   16'd0,     1'b0, 8'h12, 8'h34);

        // start held high; a/b change mid-run. Second op accepted at edge 11.
        dc = done_count;
        run_op(8'd3, 8'd5, 16'd15, 1'b1, 8'd200, 8'd100);
        check("single_done", 32'(done_count - dc), 32'd1);
        @(posedge clk);
        sb_q.push_back(16'd20000);
        #1 check("restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        begin
            int lat = 0;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk); #1;
                if (done) begin lat = n; break; end
            end
            check("restart_latency", 32'(lat), 32'd9);
        end
        @(posedge clk);

        // Reset asserted just after RUN edge 5 (clk high).
        @(negedge clk);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy),  32'd0);
        check("midrst_ebl",  32'(ebl_o), 32'd0);
        check("midrst_lds",  32'(lds_o), 32'd0);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd6, 8'd7, 16'd42, 1'b0, 8'd1, 8'd1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("total_dones", 32'(done_count), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
